// File: rtl/sprite_dma_pkg.sv
// sprite_dma_pkg: constants shared between the sprite DMA engine and the
// video top level.
//   - State encoding of the DMA FSM (IDLE/READ/COPY/DONE).
//   - Default address/data widths and transfer length.
package sprite_dma_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] COPY = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = IDLE,
    S_READ = READ,
    S_COPY = COPY,
    S_DONE = DONE
  } state_t;

  localparam int SPR_SRC_AW = 12;  // CPU work RAM address width
  localparam int SPR_DST_AW = 7;   // sprite buffer RAM address width
  localparam int SPR_DW     = 8;   // data width of both RAMs
  localparam int SPR_LEN    = 128; // bytes copied per transfer

endpackage

// File: rtl/sprite_dma.sv
// sprite_dma: copies LEN bytes from the CPU work RAM (registered-read,
// single port) into the sprite buffer RAM. One read is kept in flight
// ahead of each write, so a transfer takes LEN+2 cycles when not held.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start, src_base       transfer request and source start address
//   hold                  freezes the engine for one cycle (READ/COPY only)
//   src_addr/rd_n/ce_n    source RAM strobes (active-low), src_q read data
//   dst_addr/din/wr_n/ce_n destination RAM strobes (active-low)
//   busy, done            transfer in progress, one-cycle completion pulse
//   dbg_state_o           current FSM state, for observation only
//
// Handshake: start is a level sampled only in IDLE; a start seen in any
// other state is dropped, never queued. done is a single-cycle pulse with
// busy still high; the next start can be taken in the following IDLE cycle.
module sprite_dma
  import sprite_dma_pkg::*;
#(
  parameter int SRC_AW = SPR_SRC_AW,
  parameter int DST_AW = SPR_DST_AW,
  parameter int DW     = SPR_DW,
  parameter int LEN    = SPR_LEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              hold,
  input  logic [SRC_AW-1:0] src_base,
  output logic [SRC_AW-1:0] src_addr,
  output logic              src_rd_n,
  output logic              src_ce_n,
  input  logic [DW-1:0]     src_q,
  output logic [DST_AW-1:0] dst_addr,
  output logic [DW-1:0]     dst_din,
  output logic              dst_wr_n,
  output logic              dst_ce_n,
  output logic              busy,
  output logic              done,
  output logic [1:0]        dbg_state_o
);

  // Read counter needs one extra bit to reach LEN itself (LEN may be
  // 2^DST_AW); the write counter never needs to hold more than LEN-1.
  localparam logic [DST_AW:0]   RC_LEN  = (DST_AW+1)'(LEN);
  localparam logic [DST_AW-1:0] WC_LAST = DST_AW'(LEN - 1);

  state_t            state_q, state_d;
  logic [SRC_AW-1:0] base_q, base_d;
  logic [DST_AW:0]   rc_q, rc_d;
  logic [DST_AW-1:0] wc_q, wc_d;
  logic [SRC_AW-1:0] rd_addr;

  // Source address wraps modulo 2^SRC_AW.
  assign rd_addr     = base_q + SRC_AW'(rc_q);
  assign dbg_state_o = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      rc_q    <= '0;
      wc_q    <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      rc_q    <= rc_d;
      wc_q    <= wc_d;
    end
  end

  // Outputs decode from the state/counter registers plus hold; in IDLE
  // they all sit at their reset values, so an asynchronous reset shows on
  // the pins immediately.
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    rc_d     = rc_q;
    wc_d     = wc_q;
    src_addr = '0;
    src_rd_n = 1'b1;
    src_ce_n = 1'b1;
    dst_addr = '0;
    dst_din  = '0;
    dst_wr_n = 1'b1;
    dst_ce_n = 1'b1;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d  = src_base;
          rc_d    = '0;
          wc_d    = '0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        busy     = 1'b1;
        src_ce_n = 1'b0;
        src_addr = rd_addr;
        if (!hold) begin
          src_rd_n = 1'b0;
          rc_d     = rc_q + 1'b1;
          state_d  = S_COPY;
        end
      end
      S_COPY: begin
        busy     = 1'b1;
        src_ce_n = 1'b0;
        src_addr = rd_addr;
        dst_addr = wc_q;
        dst_din  = src_q;
        // A held cycle leaves rd_n high, so the RAM keeps src_q stable
        // for the write that resumes afterwards.
        if (!hold) begin
          dst_wr_n = 1'b0;
          dst_ce_n = 1'b0;
          wc_d     = wc_q + 1'b1;
          if (rc_q < RC_LEN) begin
            src_rd_n = 1'b0;
            rc_d     = rc_q + 1'b1;
          end
          if (wc_q == WC_LAST) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        src_ce_n = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
